// File: rtl/branch_predict_ctrl.sv
// ============================================================================
// Module   : branch_predict_ctrl
// Brief    : Direct-mapped 2-bit counter branch predictor with BTB and
//            E-stage misprediction recovery for a 5-stage RISC-V pipeline.
// Revision : 1.0
// ============================================================================
`default_nettype none

module branch_predict_ctrl #(
    parameter int IDX_W = 4,
    parameter int TAG_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      pcF,
    output logic             predict_taken_F,
    output logic [31:0]      predict_target_F,
    input  logic             ex_valid,
    input  logic             ex_is_branch,
    input  logic [31:0]      ex_pc,
    input  logic             ex_taken,
    input  logic [31:0]      ex_target,
    input  logic             ex_pred_taken,
    input  logic [31:0]      ex_pred_target,
    output logic             predict_fail,
    output logic [1:0]       pcmux_sel_out,
    output logic [31:0]      redirect_pc,
    output logic             flush_D,
    output logic             flush_E,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    localparam int         c_ENTRIES  = 1 << IDX_W;
    localparam logic [1:0] c_SEL_PC4  = 2'd0;
    localparam logic [1:0] c_SEL_PRED = 2'd1;
    localparam logic [1:0] c_SEL_EXT  = 2'd2;
    localparam logic [1:0] c_SEL_EXN  = 2'd3;
    localparam logic [1:0] c_CTR_WNT  = 2'b01;
    localparam logic [1:0] c_CTR_WT   = 2'b10;

    logic             r_valid_q  [c_ENTRIES];
    logic [TAG_W-1:0] r_tag_q    [c_ENTRIES];
    logic [31:0]      r_target_q [c_ENTRIES];
    logic [1:0]       r_ctr_q    [c_ENTRIES];
    logic [CNT_W-1:0] r_br_cnt_q;
    logic [CNT_W-1:0] r_miss_cnt_q;

    logic             w_valid_d  [c_ENTRIES];
    logic [TAG_W-1:0] w_tag_d    [c_ENTRIES];
    logic [31:0]      w_target_d [c_ENTRIES];
    logic [1:0]       w_ctr_d    [c_ENTRIES];
    logic [CNT_W-1:0] w_br_cnt_d;
    logic [CNT_W-1:0] w_miss_cnt_d;

    logic [IDX_W-1:0] w_idx_f;
    logic [TAG_W-1:0] w_tag_f;
    logic [IDX_W-1:0] w_idx_e;
    logic [TAG_W-1:0] w_tag_e;
    logic             w_hit_f;
    logic             w_hit_e;
    logic             w_br_fail;
    logic             w_alias_fail;

    assign w_idx_f = pcF[IDX_W+1:2];
    assign w_tag_f = pcF[IDX_W+TAG_W+1:IDX_W+2];
    assign w_idx_e = ex_pc[IDX_W+1:2];
    assign w_tag_e = ex_pc[IDX_W+TAG_W+1:IDX_W+2];

    assign w_hit_f = r_valid_q[w_idx_f] && (r_tag_q[w_idx_f] == w_tag_f);
    assign w_hit_e = r_valid_q[w_idx_e] && (r_tag_q[w_idx_e] == w_tag_e);

    assign predict_taken_F  = w_hit_f && r_ctr_q[w_idx_f][1];
    assign predict_target_F = predict_taken_F ? r_target_q[w_idx_f] : 32'd0;

    assign w_br_fail    = ex_valid && ex_is_branch &&
                          ((ex_taken != ex_pred_taken) ||
                           (ex_taken && (ex_pred_target != ex_target)));
    // A predicted-taken non-branch means the BTB entry belongs to another PC.
    assign w_alias_fail = ex_valid && !ex_is_branch && ex_pred_taken;
    assign predict_fail = w_br_fail || w_alias_fail;
    assign flush_D      = predict_fail;
    assign flush_E      = predict_fail;

    always_comb begin
        pcmux_sel_out = c_SEL_PC4;
        redirect_pc   = 32'd0;
        if (predict_fail && ex_is_branch && ex_taken) begin
            pcmux_sel_out = c_SEL_EXT;
            redirect_pc   = ex_target;
        end else if (predict_fail) begin
            pcmux_sel_out = c_SEL_EXN;
            redirect_pc   = ex_pc + 32'd4;
        end else if (predict_taken_F) begin
            pcmux_sel_out = c_SEL_PRED;
        end
    end

    always_comb begin
        w_valid_d    = r_valid_q;
        w_tag_d      = r_tag_q;
        w_target_d   = r_target_q;
        w_ctr_d      = r_ctr_q;
        w_br_cnt_d   = r_br_cnt_q;
        w_miss_cnt_d = r_miss_cnt_q;
        if (ex_valid) begin
            if (ex_is_branch) begin
                if (w_hit_e) begin
                    if (ex_taken) begin
                        if (r_ctr_q[w_idx_e] != 2'b11) begin
                            w_ctr_d[w_idx_e] = r_ctr_q[w_idx_e] + 2'd1;
                        end
                        w_target_d[w_idx_e] = ex_target;
                    end else if (r_ctr_q[w_idx_e] != 2'b00) begin
                        w_ctr_d[w_idx_e] = r_ctr_q[w_idx_e] - 2'd1;
                    end
                end else if (ex_taken) begin
                    w_valid_d[w_idx_e]  = 1'b1;
                    w_tag_d[w_idx_e]    = w_tag_e;
                    w_target_d[w_idx_e] = ex_target;
                    w_ctr_d[w_idx_e]    = c_CTR_WT;
                end
                if (r_br_cnt_q != {CNT_W{1'b1}}) begin
                    w_br_cnt_d = r_br_cnt_q + 1'b1;
                end
            end else if (ex_pred_taken) begin
                w_valid_d[w_idx_e] = 1'b0;
            end
        end
        if (predict_fail && (r_miss_cnt_q != {CNT_W{1'b1}})) begin
            w_miss_cnt_d = r_miss_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_ENTRIES; i++) begin
                r_valid_q[i]  <= 1'b0;
                r_tag_q[i]    <= '0;
                r_target_q[i] <= 32'd0;
                r_ctr_q[i]    <= c_CTR_WNT;
            end
            r_br_cnt_q   <= '0;
            r_miss_cnt_q <= '0;
        end else begin
            r_valid_q    <= w_valid_d;
            r_tag_q      <= w_tag_d;
            r_target_q   <= w_target_d;
            r_ctr_q      <= w_ctr_d;
            r_br_cnt_q   <= w_br_cnt_d;
            r_miss_cnt_q <= w_miss_cnt_d;
        end
    end

    assign br_cnt   = r_br_cnt_q;
    assign miss_cnt = r_miss_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_branch_predict_ctrl.sv
// ============================================================================
// Module   : tb_branch_predict_ctrl
// Brief    : Directed plus randomized self-checking bench for branch_predict_ctrl.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_branch_predict_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pcF;
    logic        predict_taken_F;
    logic [31:0] predict_target_F;
    logic        ex_valid, ex_is_branch, ex_taken, ex_pred_taken;
    logic [31:0] ex_pc, ex_target, ex_pred_target;
    logic        predict_fail;
    logic [1:0]  pcmux_sel_out;
    logic [31:0] redirect_pc;
    logic        flush_D, flush_E;
    logic [15:0] br_cnt, miss_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model: one record per table slot, counters as plain integers 0..3.
    bit          m_valid [16];
    int          m_tag   [16];
    logic [31:0] m_tgt   [16];
    int          m_ctr   [16];
    int          m_br;
    int          m_miss;

    always #5 clk = ~clk;

    branch_predict_ctrl #(.IDX_W(4), .TAG_W(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .pcF(pcF),
        .predict_taken_F(predict_taken_F), .predict_target_F(predict_target_F),
        .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_pc(ex_pc),
        .ex_taken(ex_taken), .ex_target(ex_target),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .predict_fail(predict_fail), .pcmux_sel_out(pcmux_sel_out),
        .redirect_pc(redirect_pc), .flush_D(flush_D), .flush_E(flush_E),
        .br_cnt(br_cnt), .miss_cnt(miss_cnt)
    );

    function automatic int idx_of(logic [31:0] pc);
        return int'((pc / 4) % 16);
    endfunction

    function automatic int tag_of(logic [31:0] pc);
        return int'((pc / 64) % 256);
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 0;
            m_tgt[i]   = 32'd0;
            m_ctr[i]   = 1;
        end
        m_br   = 0;
        m_miss = 0;
    endtask

    function automatic bit model_pred(logic [31:0] pc);
        int i;
        i = idx_of(pc);
        return m_valid[i] && (m_tag[i] == tag_of(pc)) && (m_ctr[i] >= 2);
    endfunction

    task automatic set_ex(bit v, bit b, logic [31:0] pc, bit tk, logic [31:0] tg,
                          bit pt, logic [31:0] ptg);
        ex_valid = v; ex_is_branch = b; ex_pc = pc; ex_taken = tk;
        ex_target = tg; ex_pred_taken = pt; ex_pred_target = ptg;
    endtask

    // Check all outputs against the model for the current inputs, then clock once.
    task automatic cycle();
        bit          ptk, fail, hit;
        logic [31:0] ptg, rpc;
        logic [31:0] sel;
        int          e;
        #1;
        ptk = model_pred(pcF);
        ptg = ptk ? m_tgt[idx_of(pcF)] : 32'd0;
        fail = 1'b0;
        if (ex_valid) begin
            if (ex_is_branch)
                fail = (ex_taken != ex_pred_taken) ||
                       (ex_taken && (ex_pred_target != ex_target));
            else
                fail = ex_pred_taken;
        end
        if (fail && ex_is_branch && ex_taken) begin
            sel = 2; rpc = ex_target;
        end else if (fail) begin
            sel = 3; rpc = ex_pc + 32'd4;
        end else begin
            sel = ptk ? 1 : 0; rpc = 32'd0;
        end
        check("predict_taken_F", {31'd0, predict_taken_F}, {31'd0, ptk});
        check("predict_target_F", predict_target_F, ptg);
        check("predict_fail", {31'd0, predict_fail}, {31'd0, fail});
        check("pcmux_sel_out", {30'd0, pcmux_sel_out}, sel);
        check("redirect_pc", redirect_pc, rpc);
        check("flush_D", {31'd0, flush_D}, {31'd0, fail});
        check("flush_E", {31'd0, flush_E}, {31'd0, fail});
        check("br_cnt", {16'd0, br_cnt}, m_br);
        check("miss_cnt", {16'd0, miss_cnt}, m_miss);
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (ex_valid) begin
            e   = idx_of(ex_pc);
            hit = m_valid[e] && (m_tag[e] == tag_of(ex_pc));
            if (ex_is_branch) begin
                if (m_br < 65535) m_br++;
                if (hit) begin
                    m_ctr[e] = ex_taken ? ((m_ctr[e] + 1 > 3) ? 3 : m_ctr[e] + 1)
                                        : ((m_ctr[e] - 1 < 0) ? 0 : m_ctr[e] - 1);
                    if (ex_taken) m_tgt[e] = ex_target;
                end else if (ex_taken) begin
                    m_valid[e] = 1'b1;
                    m_tag[e]   = tag_of(ex_pc);
                    m_tgt[e]   = ex_target;
                    m_ctr[e]   = 2;
                end
            end else if (ex_pred_taken) begin
                m_valid[e] = 1'b0;
            end
            if (fail && m_miss < 65535) m_miss++;
        end
        #1;
    endtask

    initial begin
        logic [31:0] rpc_pc;
        logic [31:0] targets [4];
        targets[0] = 32'h80; targets[1] = 32'hC0;
        targets[2] = 32'h400; targets[3] = 32'h1000;
        model_reset();

        // Reset, then idle fetch at 0x100.
        rst = 1'b1; pcF = 32'h100;
        set_ex(0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        cycle(); cycle();
        rst = 1'b0;
        cycle();

        // First taken branch mispredicts and allocates; then it predicts.
        set_ex(1, 1, 32'h100, 1, 32'h80, 0, 32'h0);
        cycle();
        set_ex(0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        cycle();
        check("directed_target_80", predict_target_F, 32'h80);

        // Saturate up, then one not-taken: counter drops to 10, still taken.
        for (int k = 0; k < 3; k++) begin
            set_ex(1, 1, 32'h100, 1, 32'h80, 1, 32'h80);
            cycle();
        end
        set_ex(1, 1, 32'h100, 0, 32'h0, 1, 32'h80);
        #1 check("directed_redirect_104", redirect_pc, 32'h104);
        cycle();
        set_ex(0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        cycle();

        // Alias: non-branch predicted taken invalidates the entry.
        set_ex(1, 0, 32'h100, 0, 32'h0, 1, 32'h80);
        cycle();
        set_ex(0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        cycle();

        // Reallocate, then a wrong-target taken prediction retargets to 0xC0.
        set_ex(1, 1, 32'h100, 1, 32'h80, 0, 32'h0);
        cycle();
        set_ex(1, 1, 32'h100, 1, 32'hC0, 1, 32'h80);
        #1 check("directed_redirect_C0", redirect_pc, 32'hC0);
        cycle();
        set_ex(0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        cycle();
        check("directed_target_C0", predict_target_F, 32'hC0);

        // Same-index allocate: fetch sees old contents this cycle, new next cycle.
        pcF = 32'h204;
        set_ex(1, 1, 32'h204, 1, 32'h300, 0, 32'h0);
        cycle();
        set_ex(0, 1, 32'h204, 0, 32'h0, 1, 32'h999);
        cycle();
        cycle();

        // Randomized traffic over a small PC space so hits, aliases and conflicts occur.
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 59) == 0);
            pcF = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 3) << 2);
            rpc_pc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 3) << 2);
            if (n % 97 == 0) rpc_pc = 32'hFFFF_FFFC;
            ex_valid       = ($urandom_range(0, 3) != 0);
            ex_is_branch   = ($urandom_range(0, 4) != 0);
            ex_pc          = rpc_pc;
            ex_taken       = $urandom_range(0, 1);
            ex_target      = targets[$urandom_range(0, 3)];
            if ($urandom_range(0, 1) == 1) begin
                ex_pred_taken  = model_pred(rpc_pc);
                ex_pred_target = ex_pred_taken ? m_tgt[idx_of(rpc_pc)] : 32'd0;
            end else begin
                ex_pred_taken  = $urandom_range(0, 1);
                ex_pred_target = targets[$urandom_range(0, 3)];
            end
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
